// File: rtl/aes_pkg.sv
// Shared AES state types and the byte numbering used by the decryption datapath.
// Byte k lives at data[127-8k -: 8]; state position (row r, col c) holds byte k = 4c + r.
package aes_pkg;

    localparam int NB      = 4;
    localparam int STATE_W = 128;

    typedef logic [7:0] byte_t;
    typedef byte_t      state_t [NB][NB];

    function automatic state_t unpack_state(input logic [STATE_W-1:0] vec);
        state_t s;
        for (int c = 0; c < NB; c++) begin
            for (int r = 0; r < NB; r++) begin
                s[c][r] = vec[STATE_W-1-8*(NB*c+r) -: 8];
            end
        end
        return s;
    endfunction

    function automatic logic [STATE_W-1:0] pack_state(input state_t s);
        logic [STATE_W-1:0] vec;
        vec = '0;
        for (int c = 0; c < NB; c++) begin
            for (int r = 0; r < NB; r++) begin
                vec[STATE_W-1-8*(NB*c+r) -: 8] = s[c][r];
            end
        end
        return vec;
    endfunction

endpackage

// File: rtl/inv_shift_rows_perm.sv
// Combinational byte permutation: out(r,c) = in(r, (c - r - 1) mod 4).
// This is InvShiftRows followed by a one-column rotation of the whole state.
module inv_shift_rows_perm
    import aes_pkg::*;
(
    input  logic [STATE_W-1:0] data_in,
    output logic [STATE_W-1:0] data_out
);

    state_t s_in;
    state_t s_out;

    always_comb begin
        s_in = unpack_state(data_in);
        for (int c = 0; c < NB; c++) begin
            for (int r = 0; r < NB; r++) begin
                // +2*NB keeps the modulo operand non-negative
                s_out[c][r] = s_in[(c - r - 1 + 2*NB) % NB][r];
            end
        end
        data_out = pack_state(s_out);
    end

endmodule

// File: rtl/inv_shift_rows.sv
// Registered InvShiftRows stage (with column rotation) carrying a valid flag, latency 1.
// Defining INV_SHIFT_ROWS_COMB_OUT_EN adds the unregistered data_comb output.
module inv_shift_rows
    import aes_pkg::*;
#(
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] data_in,
`ifdef INV_SHIFT_ROWS_COMB_OUT_EN
    output logic [DATA_W-1:0] data_comb,
`endif
    output logic              out_valid,
    output logic [DATA_W-1:0] data_out
);

    generate
        if (DATA_W != STATE_W) begin : g_width_check
            $error("inv_shift_rows: DATA_W must be 128");
        end
    endgenerate

    logic [STATE_W-1:0] perm_data;

    inv_shift_rows_perm u_perm (
        .data_in  (data_in),
        .data_out (perm_data)
    );

`ifdef INV_SHIFT_ROWS_COMB_OUT_EN
    assign data_comb = perm_data;
`endif

    // data_out only loads on a valid beat so it holds through bubbles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            data_out  <= '0;
        end else begin
            out_valid <= (in_valid === 1'b1);
            if (in_valid) begin
                data_out <= perm_data;
            end
        end
    end

endmodule

// File: tb/tb_inv_shift_rows.sv
// Self-checking bench for inv_shift_rows: directed vectors, streaming, hold, async reset, random.
// Also checks data_comb when INV_SHIFT_ROWS_COMB_OUT_EN is defined.
module tb_inv_shift_rows;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic [127:0] data_in;
    logic         out_valid;
    logic [127:0] data_out;
`ifdef INV_SHIFT_ROWS_COMB_OUT_EN
    logic [127:0] data_comb;
`endif

    int           num_checks;
    int           num_fails;
    logic         exp_valid;
    logic [127:0] exp_data;
    logic [127:0] held;

    inv_shift_rows #(.DATA_W(128)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .data_in   (data_in),
`ifdef INV_SHIFT_ROWS_COMB_OUT_EN
        .data_comb (data_comb),
`endif
        .out_valid (out_valid),
        .data_out  (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: output byte at (row r, col c) comes from input (row r, col (c-r-1) mod 4)
    function automatic logic [127:0] model_perm(input logic [127:0] x);
        logic [7:0]   b [16];
        logic [127:0] y;
        int           r, c, src_c;
        for (int k = 0; k < 16; k++) b[k] = x[127-8*k -: 8];
        y = '0;
        for (int k = 0; k < 16; k++) begin
            r     = k % 4;
            c     = k / 4;
            src_c = (c - r - 1 + 8) % 4;
            y[127-8*k -: 8] = b[4*src_c + r];
        end
        return y;
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        num_checks++;
        assert (observed === expected)
        else begin
            num_fails++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic checkRegs(input string tag);
        checkOutput({tag, "_valid"}, {127'd0, out_valid}, {127'd0, exp_valid});
        checkOutput({tag, "_data"}, data_out, exp_data);
    endtask

    // Drive on the falling edge, optionally check the comb path, then sample #1 after the rising edge
    task automatic applyStimulus(input logic v, input logic [127:0] d);
        in_valid = v;
        data_in  = d;
`ifdef INV_SHIFT_ROWS_COMB_OUT_EN
        #1;
        checkOutput("comb", data_comb, model_perm(d));
`endif
        @(posedge clk);
        if (rst) begin
            exp_valid = 1'b0;
            exp_data  = '0;
        end else begin
            exp_valid = v;
            if (v) exp_data = model_perm(d);
        end
        #1;
        @(negedge clk);
    endtask

    initial begin
        num_checks = 0;
        num_fails  = 0;
        rst        = 1'b1;
        in_valid   = 1'b0;
        data_in    = '0;
        exp_valid  = 1'b0;
        exp_data   = '0;

        @(negedge clk);
        checkRegs("reset");
        applyStimulus(1'b1, 128'h0123456789abcdef0123456789abcdef);
        checkRegs("reset_ignores_valid");
        rst = 1'b0;

        applyStimulus(1'b1, 128'h7b5b54657374566563746f725d53475d);
        checkRegs("vector");
        checkOutput("vector_const", data_out, 128'h5d7456657b536f65735b47726374545d);

        applyStimulus(1'b1, 128'h000102030405060708090a0b0c0d0e0f);
        checkOutput("index_map", data_out, 128'h0c090603000d0a0704010e0b0805020f);

        applyStimulus(1'b1, '0);
        checkRegs("stream_zero");
        checkOutput("zero_fixed", data_out, '0);
        applyStimulus(1'b1, 128'h000102030405060708090a0b0c0d0e0f);
        checkRegs("stream_index");
        applyStimulus(1'b1, '1);
        checkRegs("stream_ones");
        checkOutput("ones_fixed", data_out, '1);

        applyStimulus(1'b1, 128'hdeadbeef_cafef00d_01234567_89abcdef);
        held = data_out;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, {$urandom, $urandom, $urandom, $urandom});
            checkRegs("hold");
            checkOutput("hold_unchanged", data_out, held);
        end

        applyStimulus(1'b1, 128'h1f2e3d4c5b6a79880706050403020100);
        checkRegs("pre_reset");
        #2;
        rst = 1'b1;
        #1;
        exp_valid = 1'b0;
        exp_data  = '0;
        checkRegs("async_reset");
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1'b1, 128'h00112233445566778899aabbccddeeff);
        checkRegs("after_reset");

        for (int i = 0; i < 40; i++) begin
            applyStimulus(($urandom_range(0, 3) != 0), {$urandom, $urandom, $urandom, $urandom});
            checkRegs("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
        $finish;
    end

endmodule
